mcu_bus_sequencer: RTL and testbench

MCU-level sequencer sitting between the Core, the debug/boot port and the unified memory bus. Owns the MCU run state (boot, run, pausing, paused, resume) and drives the Core's pause/boot handshake. Grants the single memory bus to the debug port only while the Core is held in boot or is fully paused. Memory read data is combinational (same-cycle).

---
 rtl/mcu_bus_sequencer_pkg.sv | 18 +
 rtl/mcu_bus_sequencer_if.sv | 52 +++++
 rtl/mcu_bus_sequencer_bus_owner_mux.sv | 31 +++
 rtl/mcu_bus_sequencer.sv | 88 ++++++++
 tb/tb_mcu_bus_sequencer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mcu_bus_sequencer_pkg.sv
// Shared definitions for the MCU bus sequencer: run-state encodings,
// pause-cause bit positions and the memory bus width.
package mcu_bus_sequencer_pkg;

  localparam int BUS_W = 16;

  localparam int CAUSE_PSE = 0;
  localparam int CAUSE_DBG = 1;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PAUSING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_RESUME  = 3'd4
  } state_e;

endpackage

// File: rtl/mcu_bus_sequencer_if.sv
// Core / debug-port / memory bundle seen by the sequencer.
// The slave modport is the sequencer's view; master is the surrounding MCU.
interface mcu_bus_sequencer_if;
  import mcu_bus_sequencer_pkg::*;

  logic [BUS_W-1:0] i_coreAddr;
  logic [BUS_W-1:0] i_coreWData;
  logic             i_coreWr;
  logic [BUS_W-1:0] o_coreRData;
  logic             i_coreDoPause;
  logic             o_coreStartPause;
  logic             i_coreNowPaused;
  logic             o_coreIsBooted;

  logic             i_dbgReq;
  logic [BUS_W-1:0] i_dbgAddr;
  logic [BUS_W-1:0] i_dbgWData;
  logic             i_dbgWr;
  logic             o_dbgGnt;
  logic [BUS_W-1:0] o_dbgRData;
  logic             o_dbgValid;
  logic             i_dbgBootDone;
  logic             i_dbgPause;
  logic             i_dbgResume;

  logic [BUS_W-1:0] o_memAddr;
  logic [BUS_W-1:0] o_memWData;
  logic             o_memWr;
  logic [BUS_W-1:0] i_memRData;

  logic [2:0]       o_state;
  logic [1:0]       o_pauseCause;

  modport slave (
    input  i_coreAddr, i_coreWData, i_coreWr, i_coreDoPause, i_coreNowPaused,
    input  i_dbgReq, i_dbgAddr, i_dbgWData, i_dbgWr,
    input  i_dbgBootDone, i_dbgPause, i_dbgResume, i_memRData,
    output o_coreRData, o_coreStartPause, o_coreIsBooted,
    output o_dbgGnt, o_dbgRData, o_dbgValid,
    output o_memAddr, o_memWData, o_memWr, o_state, o_pauseCause
  );

  modport master (
    output i_coreAddr, i_coreWData, i_coreWr, i_coreDoPause, i_coreNowPaused,
    output i_dbgReq, i_dbgAddr, i_dbgWData, i_dbgWr,
    output i_dbgBootDone, i_dbgPause, i_dbgResume, i_memRData,
    input  o_coreRData, o_coreStartPause, o_coreIsBooted,
    input  o_dbgGnt, o_dbgRData, o_dbgValid,
    input  o_memAddr, o_memWData, o_memWr, o_state, o_pauseCause
  );

endinterface

// File: rtl/mcu_bus_sequencer_bus_owner_mux.sv
// Selects Core or debug port onto the memory bus. A debug owner without a
// grant must never write, so its write enable is gated by the grant.
module mcu_bus_sequencer_bus_owner_mux
  import mcu_bus_sequencer_pkg::*;
(
  input  logic             dbg_owns_i,
  input  logic             dbg_gnt_i,
  input  logic [BUS_W-1:0] core_addr_i,
  input  logic [BUS_W-1:0] core_wdata_i,
  input  logic             core_wr_i,
  input  logic [BUS_W-1:0] dbg_addr_i,
  input  logic [BUS_W-1:0] dbg_wdata_i,
  input  logic             dbg_wr_i,
  output logic [BUS_W-1:0] mem_addr_o,
  output logic [BUS_W-1:0] mem_wdata_o,
  output logic             mem_wr_o
);

  always_comb begin
    if (dbg_owns_i) begin
      mem_addr_o  = dbg_addr_i;
      mem_wdata_o = dbg_wdata_i;
      mem_wr_o    = dbg_gnt_i & dbg_wr_i;
    end else begin
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
      mem_wr_o    = core_wr_i;
    end
  end

endmodule

// File: rtl/mcu_bus_sequencer.sv
// MCU run-state sequencer: boot/run/pause/resume control of the Core and
// arbitration of the single memory bus between Core and debug port.
module mcu_bus_sequencer
  import mcu_bus_sequencer_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rstn,
  mcu_bus_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  logic [1:0]       cause_q, cause_d;
  logic [BUS_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic             dbg_valid_q, dbg_valid_d;
  logic             dbg_owns, dbg_gnt, dbg_rd;

  always_comb begin
    dbg_owns    = (state_q == ST_BOOT) || (state_q == ST_PAUSED);
    dbg_gnt     = dbg_owns & bus.i_dbgReq;
    dbg_rd      = dbg_gnt & ~bus.i_dbgWr;
    dbg_rdata_d = dbg_rd ? bus.i_memRData : dbg_rdata_q;
    dbg_valid_d = dbg_rd;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_BOOT:    if (bus.i_dbgBootDone) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.i_coreDoPause || bus.i_dbgPause) begin
          state_d              = ST_PAUSING;
          cause_d[CAUSE_PSE]   = bus.i_coreDoPause;
          cause_d[CAUSE_DBG]   = bus.i_dbgPause;
        end
      end
      ST_PAUSING: if (bus.i_coreNowPaused) state_d = ST_PAUSED;
      // A resume that coincides with a debug access waits for a quiet cycle.
      ST_PAUSED: begin
        if (bus.i_dbgResume && !bus.i_dbgReq) begin
          state_d = ST_RESUME;
          cause_d = 2'b00;
        end
      end
      // PSE is not sampled here, giving the Core one unpaused cycle.
      ST_RESUME:  state_d = ST_RUN;
      default:    state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_BOOT;
      cause_q     <= 2'b00;
      dbg_rdata_q <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      dbg_rdata_q <= dbg_rdata_d;
      dbg_valid_q <= dbg_valid_d;
    end
  end

  mcu_bus_sequencer_bus_owner_mux u_mux (
    .dbg_owns_i   (dbg_owns),
    .dbg_gnt_i    (dbg_gnt),
    .core_addr_i  (bus.i_coreAddr),
    .core_wdata_i (bus.i_coreWData),
    .core_wr_i    (bus.i_coreWr),
    .dbg_addr_i   (bus.i_dbgAddr),
    .dbg_wdata_i  (bus.i_dbgWData),
    .dbg_wr_i     (bus.i_dbgWr),
    .mem_addr_o   (bus.o_memAddr),
    .mem_wdata_o  (bus.o_memWData),
    .mem_wr_o     (bus.o_memWr)
  );

  assign bus.o_coreRData      = bus.i_memRData;
  assign bus.o_coreIsBooted   = (state_q != ST_BOOT);
  assign bus.o_coreStartPause = (state_q == ST_PAUSING) || (state_q == ST_PAUSED);
  assign bus.o_dbgGnt         = dbg_gnt;
  assign bus.o_dbgRData       = dbg_rdata_q;
  assign bus.o_dbgValid       = dbg_valid_q;
  assign bus.o_state          = state_q;
  assign bus.o_pauseCause     = cause_q;

endmodule

// File: tb/tb_mcu_bus_sequencer.sv
// Directed bench for mcu_bus_sequencer with a small word-addressed memory model.
module tb_mcu_bus_sequencer;

  logic i_clk = 1'b0;
  logic i_rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [0:255];

  mcu_bus_sequencer_if bus ();

  mcu_bus_sequencer dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  assign bus.i_memRData = mem[bus.o_memAddr[7:0]];

  always @(posedge i_clk) begin
    if (bus.o_memWr) mem[bus.o_memAddr[7:0]] <= bus.o_memWData;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_coreAddr = 16'h0; bus.i_coreWData = 16'h0; bus.i_coreWr = 1'b0;
    bus.i_coreDoPause = 1'b0; bus.i_coreNowPaused = 1'b0;
    bus.i_dbgReq = 1'b0; bus.i_dbgAddr = 16'h0; bus.i_dbgWData = 16'h0; bus.i_dbgWr = 1'b0;
    bus.i_dbgBootDone = 1'b0; bus.i_dbgPause = 1'b0; bus.i_dbgResume = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rstn = 1'b0;
    tick(); tick();
    checks++; if (bus.o_state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.o_state); end
    checks++; if (bus.o_coreIsBooted !== 1'b0 || bus.o_coreStartPause !== 1'b0) begin errors++; $display("FAIL rst_core got booted=%b start=%b exp 0 0", bus.o_coreIsBooted, bus.o_coreStartPause); end
    checks++; if (bus.o_dbgGnt !== 1'b0 || bus.o_dbgValid !== 1'b0 || bus.o_dbgRData !== 16'h0) begin errors++; $display("FAIL rst_dbg got gnt=%b vld=%b rdata=%h exp 0 0 0000", bus.o_dbgGnt, bus.o_dbgValid, bus.o_dbgRData); end
    checks++; if (bus.o_pauseCause !== 2'b00 || bus.o_memWr !== 1'b0) begin errors++; $display("FAIL rst_misc got cause=%b memwr=%b exp 00 0", bus.o_pauseCause, bus.o_memWr); end
    @(negedge i_clk); i_rstn = 1'b1;
    #1;
    bus.i_dbgPause = 1'b1;
    tick();
    checks++; if (bus.o_state !== 3'd0) begin errors++; $display("FAIL boot_ignores_pause got %0d exp 0", bus.o_state); end
    bus.i_dbgPause = 1'b0;
  endtask

  task automatic test_boot_load();
    bus.i_dbgReq = 1'b1; bus.i_dbgWr = 1'b1; bus.i_dbgAddr = 16'h0010; bus.i_dbgWData = 16'hA5A5;
    bus.i_coreAddr = 16'h0040; bus.i_coreWr = 1'b1;
    #1;
    checks++; if (bus.o_dbgGnt !== 1'b1 || bus.o_memWr !== 1'b1) begin errors++; $display("FAIL boot_wr_gnt got gnt=%b memwr=%b exp 1 1", bus.o_dbgGnt, bus.o_memWr); end
    checks++; if (bus.o_memAddr !== 16'h0010 || bus.o_memWData !== 16'hA5A5) begin errors++; $display("FAIL boot_wr_bus got addr=%h wdata=%h exp 0010 a5a5", bus.o_memAddr, bus.o_memWData); end
    tick();
    checks++; if (bus.o_dbgValid !== 1'b0) begin errors++; $display("FAIL boot_wr_novalid got %b exp 0", bus.o_dbgValid); end
    bus.i_dbgReq = 1'b0; bus.i_dbgBootDone = 1'b1;
    #1;
    checks++; if (bus.o_memWr !== 1'b0 || bus.o_coreIsBooted !== 1'b0) begin errors++; $display("FAIL boot_nognt_wr got memwr=%b booted=%b exp 0 0", bus.o_memWr, bus.o_coreIsBooted); end
    tick();
    bus.i_dbgBootDone = 1'b0; bus.i_coreWr = 1'b0; bus.i_dbgWr = 1'b0;
    checks++; if (bus.o_state !== 3'd1 || bus.o_coreIsBooted !== 1'b1) begin errors++; $display("FAIL boot_to_run got state=%0d booted=%b exp 1 1", bus.o_state, bus.o_coreIsBooted); end
  endtask

  task automatic test_debug_blocked_run();
    bus.i_coreAddr = 16'h0020; bus.i_coreWData = 16'h1234; bus.i_coreWr = 1'b1;
    bus.i_dbgReq = 1'b1; bus.i_dbgWr = 1'b1; bus.i_dbgAddr = 16'h0030; bus.i_dbgWData = 16'hDEAD;
    #1;
    checks++; if (bus.o_dbgGnt !== 1'b0) begin errors++; $display("FAIL run_gnt got %b exp 0", bus.o_dbgGnt); end
    checks++; if (bus.o_memAddr !== 16'h0020 || bus.o_memWData !== 16'h1234 || bus.o_memWr !== 1'b1) begin errors++; $display("FAIL run_bus got addr=%h wdata=%h wr=%b exp 0020 1234 1", bus.o_memAddr, bus.o_memWData, bus.o_memWr); end
    checks++; if (bus.o_coreRData !== 16'h1020) begin errors++; $display("FAIL run_rdata_pre got %h exp 1020", bus.o_coreRData); end
    tick();
    bus.i_coreWr = 1'b0; bus.i_dbgReq = 1'b0; bus.i_dbgWr = 1'b0;
    #1;
    checks++; if (bus.o_coreRData !== 16'h1234) begin errors++; $display("FAIL run_rdata_post got %h exp 1234", bus.o_coreRData); end
    checks++; if (mem[8'h30] !== 16'h1030) begin errors++; $display("FAIL run_dbg_nowrite got %h exp 1030", mem[8'h30]); end
  endtask

  task automatic test_pse_pause();
    bus.i_coreDoPause = 1'b1;
    #1;
    checks++; if (bus.o_coreStartPause !== 1'b0) begin errors++; $display("FAIL pse_early got %b exp 0", bus.o_coreStartPause); end
    tick();
    bus.i_coreDoPause = 1'b0;
    checks++; if (bus.o_state !== 3'd2 || bus.o_coreStartPause !== 1'b1 || bus.o_pauseCause !== 2'b01) begin errors++; $display("FAIL pse_pausing got state=%0d start=%b cause=%b exp 2 1 01", bus.o_state, bus.o_coreStartPause, bus.o_pauseCause); end
    bus.i_dbgReq = 1'b1; bus.i_dbgAddr = 16'h0010; bus.i_coreAddr = 16'h0022;
    #1;
    checks++; if (bus.o_dbgGnt !== 1'b0 || bus.o_memAddr !== 16'h0022) begin errors++; $display("FAIL pausing_blocked got gnt=%b addr=%h exp 0 0022", bus.o_dbgGnt, bus.o_memAddr); end
    bus.i_dbgReq = 1'b0; bus.i_coreNowPaused = 1'b1;
    tick();
    bus.i_coreNowPaused = 1'b0;
    checks++; if (bus.o_state !== 3'd3 || bus.o_coreStartPause !== 1'b1) begin errors++; $display("FAIL pse_paused got state=%0d start=%b exp 3 1", bus.o_state, bus.o_coreStartPause); end
    bus.i_dbgReq = 1'b1; bus.i_dbgWr = 1'b0; bus.i_dbgAddr = 16'h0010;
    #1;
    checks++; if (bus.o_dbgGnt !== 1'b1 || bus.o_dbgValid !== 1'b0) begin errors++; $display("FAIL rd_grant got gnt=%b vld=%b exp 1 0", bus.o_dbgGnt, bus.o_dbgValid); end
    tick();
    bus.i_dbgReq = 1'b0;
    checks++; if (bus.o_dbgValid !== 1'b1 || bus.o_dbgRData !== 16'hA5A5) begin errors++; $display("FAIL rd_data got vld=%b rdata=%h exp 1 a5a5", bus.o_dbgValid, bus.o_dbgRData); end
    tick();
    checks++; if (bus.o_dbgValid !== 1'b0 || bus.o_dbgRData !== 16'hA5A5) begin errors++; $display("FAIL rd_pulse got vld=%b rdata=%h exp 0 a5a5", bus.o_dbgValid, bus.o_dbgRData); end
  endtask

  task automatic test_resume_mask();
    bus.i_coreDoPause = 1'b1; bus.i_dbgResume = 1'b1;
    bus.i_dbgReq = 1'b1; bus.i_dbgWr = 1'b0; bus.i_dbgAddr = 16'h0010;
    #1;
    checks++; if (bus.o_dbgGnt !== 1'b1) begin errors++; $display("FAIL resume_defer_gnt got %b exp 1", bus.o_dbgGnt); end
    tick();
    checks++; if (bus.o_state !== 3'd3) begin errors++; $display("FAIL resume_deferred got state=%0d exp 3", bus.o_state); end
    bus.i_dbgReq = 1'b0;
    tick();
    bus.i_dbgResume = 1'b0;
    checks++; if (bus.o_state !== 3'd4 || bus.o_coreStartPause !== 1'b0 || bus.o_pauseCause !== 2'b00) begin errors++; $display("FAIL resume_state got state=%0d start=%b cause=%b exp 4 0 00", bus.o_state, bus.o_coreStartPause, bus.o_pauseCause); end
    tick();
    checks++; if (bus.o_state !== 3'd1) begin errors++; $display("FAIL resume_masked got state=%0d exp 1", bus.o_state); end
    tick();
    bus.i_coreDoPause = 1'b0;
    checks++; if (bus.o_state !== 3'd2 || bus.o_pauseCause !== 2'b01) begin errors++; $display("FAIL repause got state=%0d cause=%b exp 2 01", bus.o_state, bus.o_pauseCause); end
  endtask

  task automatic test_simultaneous_pause();
    bus.i_coreNowPaused = 1'b1;
    tick();
    bus.i_coreNowPaused = 1'b0; bus.i_dbgResume = 1'b1;
    tick();
    bus.i_dbgResume = 1'b0;
    tick();
    checks++; if (bus.o_state !== 3'd1) begin errors++; $display("FAIL sim_back_to_run got state=%0d exp 1", bus.o_state); end
    bus.i_coreDoPause = 1'b1; bus.i_dbgPause = 1'b1;
    tick();
    bus.i_coreDoPause = 1'b0; bus.i_dbgPause = 1'b0;
    checks++; if (bus.o_state !== 3'd2 || bus.o_pauseCause !== 2'b11) begin errors++; $display("FAIL sim_cause got state=%0d cause=%b exp 2 11", bus.o_state, bus.o_pauseCause); end
    bus.i_coreNowPaused = 1'b1;
    tick();
    bus.i_coreNowPaused = 1'b0;
    checks++; if (bus.o_state !== 3'd3 || bus.o_pauseCause !== 2'b11) begin errors++; $display("FAIL sim_paused got state=%0d cause=%b exp 3 11", bus.o_state, bus.o_pauseCause); end
  endtask

  task automatic test_reset_mid_pause();
    bus.i_dbgReq = 1'b1; bus.i_dbgWr = 1'b0; bus.i_dbgAddr = 16'h0020;
    tick();
    bus.i_dbgReq = 1'b0;
    checks++; if (bus.o_dbgValid !== 1'b1 || bus.o_dbgRData !== 16'h1234) begin errors++; $display("FAIL mid_rd got vld=%b rdata=%h exp 1 1234", bus.o_dbgValid, bus.o_dbgRData); end
    #1 i_rstn = 1'b0;
    #1;
    checks++; if (bus.o_dbgValid !== 1'b0 || bus.o_state !== 3'd0 || bus.o_coreIsBooted !== 1'b0) begin errors++; $display("FAIL mid_reset got vld=%b state=%0d booted=%b exp 0 0 0", bus.o_dbgValid, bus.o_state, bus.o_coreIsBooted); end
    checks++; if (bus.o_coreStartPause !== 1'b0 || bus.o_pauseCause !== 2'b00 || bus.o_dbgRData !== 16'h0) begin errors++; $display("FAIL mid_reset_misc got start=%b cause=%b rdata=%h exp 0 00 0000", bus.o_coreStartPause, bus.o_pauseCause, bus.o_dbgRData); end
    @(negedge i_clk); i_rstn = 1'b1;
    tick();
    checks++; if (bus.o_state !== 3'd0) begin errors++; $display("FAIL post_reset got state=%0d exp 0", bus.o_state); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    test_reset();
    test_boot_load();
    test_debug_blocked_run();
    test_pse_pause();
    test_resume_mask();
    test_simultaneous_pause();
    test_reset_mid_pause();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
